sqwave_sequencer: RTL

Programmable step sequencer that drives the `m`/`n` on/off controls and the reset of the programmable square-wave generator (`sqwave_gen`). It holds a small table of (m, n, repeat) entries and plays them back in order, each for an exact whole number of generator periods. It restarts the generator's phase at every step change so each new setting begins cleanly with its ON phase. Typical use is between a host/register interface and `sqwave_gen` to produce scripted waveforms without software timing.

---
 rtl/sqwave_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sqwave_sequencer.sv
// sqwave_sequencer
// Step sequencer that plays a small table of (rep, m, n) entries into a
// square-wave generator. Each entry is held for (rep+1) * max(m+n,1) time
// units of TICK_CYCLES clocks, and the generator phase is restarted with a
// one-cycle low gen_rst_n pulse whenever a new entry is loaded.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset
//   wr_en      table write strobe
//   wr_addr    table write address
//   wr_data    entry {rep[11:8], m[7:4], n[3:0]}
//   last_addr  index of final entry to play, captured at start
//   loop       1: wrap to entry 0 after last_addr, captured at start
//   start      begin playback at entry 0 (honoured only when idle)
//   stop       abort playback from any state
//   m, n       ON/OFF unit counts driven to the generator
//   gen_rst_n  active-low generator restart, low for the load cycle
//   busy       high while a step is loaded or running
//   step_idx   index of the entry currently driven
//   done       one-cycle pulse on normal (non-looping) completion
//
// TICK_CYCLES is expected to be at least 2: the load cycle is counted as
// the first tick of the first unit.
module sqwave_sequencer #(
    parameter int TICK_CYCLES = 5,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [11:0]              wr_data,
    input  logic [$clog2(DEPTH)-1:0] last_addr,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    output logic [3:0]               m,
    output logic [3:0]               n,
    output logic                     gen_rst_n,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Units per period: an all-zero entry still lasts one unit.
    function automatic logic [4:0] unit_count(input logic [3:0] m_v, input logic [3:0] n_v);
        logic [4:0] sum_v;
        sum_v = {1'b0, m_v} + {1'b0, n_v};
        return (sum_v == 5'd0) ? 5'd1 : sum_v;
    endfunction

    logic [11:0]   table_r [DEPTH];
    state_t        state_r, state_s;
    logic [3:0]    m_r, m_s, n_r, n_s;
    logic          gen_rst_n_r, gen_rst_n_s;
    logic          busy_r, busy_s, done_r, done_s;
    logic [AW-1:0] step_idx_r, step_idx_s;
    logic [AW-1:0] last_addr_r, last_addr_s;
    logic          loop_r, loop_s;
    logic [TW-1:0] tick_r, tick_s;
    logic [4:0]    unit_r, unit_s, units_r, units_s;
    logic [3:0]    rep_r, rep_s;
    logic          load_s, finish_s, abort_s;
    logic [AW-1:0] load_idx_s;
    logic [11:0]   entry_s;

    // Entry table: written in any state, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= 12'd0;
            end
        end else if (wr_en) begin
            table_r[wr_addr] <= wr_data;
        end
    end

    // Next-state, counter and output computation.
    always_comb begin
        state_s     = state_r;
        m_s         = m_r;
        n_s         = n_r;
        gen_rst_n_s = 1'b1;
        busy_s      = busy_r;
        done_s      = 1'b0;
        step_idx_s  = step_idx_r;
        last_addr_s = last_addr_r;
        loop_s      = loop_r;
        tick_s      = tick_r;
        unit_s      = unit_r;
        units_s     = units_r;
        rep_s       = rep_r;
        load_s      = 1'b0;
        load_idx_s  = {AW{1'b0}};
        finish_s    = 1'b0;
        abort_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    load_s      = 1'b1;
                    last_addr_s = last_addr;
                    loop_s      = loop;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_LOAD: begin
                // The load cycle itself is tick 0 of the first unit.
                state_s = ST_RUN;
                tick_s  = TICK_ONE;
            end
            ST_RUN: begin
                if (tick_r == TICK_LAST) begin
                    tick_s = {TW{1'b0}};
                    if (unit_r == (units_r - 5'd1)) begin
                        unit_s = 5'd0;
                        if (rep_r != 4'd0) begin
                            // Another period of the same step, no generator restart.
                            rep_s = rep_r - 4'd1;
                        end else if (step_idx_r != last_addr_r) begin
                            load_s     = 1'b1;
                            load_idx_s = step_idx_r + AW'(1);
                        end else if (loop_r) begin
                            load_s     = 1'b1;
                            load_idx_s = {AW{1'b0}};
                        end else begin
                            finish_s = 1'b1;
                        end
                    end else begin
                        unit_s = unit_r + 5'd1;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            default: begin
                abort_s = 1'b1;
            end
        endcase

        // Forward a same-cycle write so it reaches the entry being loaded.
        entry_s = (wr_en && (wr_addr == load_idx_s)) ? wr_data : table_r[load_idx_s];

        if (stop || finish_s || abort_s) begin
            state_s     = ST_IDLE;
            m_s         = 4'd0;
            n_s         = 4'd0;
            gen_rst_n_s = 1'b1;
            busy_s      = 1'b0;
            step_idx_s  = {AW{1'b0}};
            tick_s      = {TW{1'b0}};
            unit_s      = 5'd0;
            units_s     = 5'd0;
            rep_s       = 4'd0;
            done_s      = finish_s && !stop;
        end else if (load_s) begin
            state_s     = ST_LOAD;
            m_s         = entry_s[7:4];
            n_s         = entry_s[3:0];
            rep_s       = entry_s[11:8];
            units_s     = unit_count(entry_s[7:4], entry_s[3:0]);
            tick_s      = {TW{1'b0}};
            unit_s      = 5'd0;
            step_idx_s  = load_idx_s;
            gen_rst_n_s = 1'b0;
            busy_s      = 1'b1;
        end else begin
            gen_rst_n_s = 1'b1;
        end
    end

    // State, counter and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            m_r         <= 4'd0;
            n_r         <= 4'd0;
            gen_rst_n_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            step_idx_r  <= {AW{1'b0}};
            last_addr_r <= {AW{1'b0}};
            loop_r      <= 1'b0;
            tick_r      <= {TW{1'b0}};
            unit_r      <= 5'd0;
            units_r     <= 5'd0;
            rep_r       <= 4'd0;
        end else begin
            state_r     <= state_s;
            m_r         <= m_s;
            n_r         <= n_s;
            gen_rst_n_r <= gen_rst_n_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            step_idx_r  <= step_idx_s;
            last_addr_r <= last_addr_s;
            loop_r      <= loop_s;
            tick_r      <= tick_s;
            unit_r      <= unit_s;
            units_r     <= units_s;
            rep_r       <= rep_s;
        end
    end

    assign m         = m_r;
    assign n         = n_r;
    assign gen_rst_n = gen_rst_n_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign step_idx  = step_idx_r;

endmodule
